// File: rtl/shot_timer_pkg.sv
// shot_timer_pkg: shared types and constants for the shot window timer.
//   phase_e  - delivery phase encoding as seen on the phase port
//   result_e - swing classification as seen on the result port
//   TICK_W   - width of the per-phase tick index
//   sat_inc8 - saturating 8-bit increment used by the statistics counters
package shot_timer_pkg;

  localparam int unsigned TICK_W = 5;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_RUNUP  = 2'd1,
    PH_WINDOW = 2'd2,
    PH_RESULT = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    RES_MISS    = 2'd0,
    RES_EARLY   = 2'd1,
    RES_PERFECT = 2'd2,
    RES_LATE    = 2'd3
  } result_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/toggle_tick.sv
// toggle_tick: turns every edge of the 10 Hz divider level into a one-cycle
// tick in the clk_fpga domain.
//   clk_fpga - master clock
//   rst_n    - asynchronous active-low reset
//   clk_10Hz - divider output level (already in the clk_fpga domain)
//   tick     - high for one cycle after each clk_10Hz toggle
module toggle_tick (
  input  logic clk_fpga,
  input  logic rst_n,
  input  logic clk_10Hz,
  output logic tick
);

  logic clk_10Hz_d;

  always_ff @(posedge clk_fpga or negedge rst_n) begin
    if (!rst_n) clk_10Hz_d <= 1'b0;
    else        clk_10Hz_d <= clk_10Hz;
  end

  assign tick = clk_10Hz ^ clk_10Hz_d;

endmodule

// File: rtl/shot_window_timer.sv
// shot_window_timer: sequences one delivery (run-up, batting window, held
// result) on 100 ms ticks and classifies the batter's swing.
//   clk_fpga, rst_n        - clock, asynchronous active-low reset
//   clk_10Hz               - divider level, each edge is one 100 ms tick
//   bowl_start             - one-cycle delivery request (honoured in IDLE only)
//   swing                  - debounced bat level, rising edge is a swing
//   phase, window_open     - current phase, high throughout WINDOW
//   result_valid, result   - one-cycle pulse on RESULT entry, held result code
//   tick_idx               - tick count within the active phase
//   perfect_count, ball_count - saturating tallies
// Build option: define SHOT_STATS_EN to enable the tallies; otherwise both
// tally ports read constant zero.
module shot_window_timer
  import shot_timer_pkg::*;
#(
  parameter int unsigned RUNUP_TICKS  = 20,
  parameter int unsigned WINDOW_TICKS = 8,
  parameter int unsigned PERFECT_LO   = 3,
  parameter int unsigned PERFECT_HI   = 4,
  parameter int unsigned RESULT_TICKS = 15
) (
  input  logic              clk_fpga,
  input  logic              rst_n,
  input  logic              clk_10Hz,
  input  logic              bowl_start,
  input  logic              swing,
  output logic [1:0]        phase,
  output logic              window_open,
  output logic              result_valid,
  output logic [1:0]        result,
  output logic [TICK_W-1:0] tick_idx,
  output logic [7:0]        perfect_count,
  output logic [7:0]        ball_count
);

  logic tick;
  logic swing_d;
  logic swing_rise;

  phase_e            state_q, state_d;
  result_e           res_q, res_d;
  logic [TICK_W-1:0] idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              wopen_q, wopen_d;
  logic [TICK_W:0]   idx_inc;

  toggle_tick u_toggle_tick (
    .clk_fpga (clk_fpga),
    .rst_n    (rst_n),
    .clk_10Hz (clk_10Hz),
    .tick     (tick)
  );

  always_ff @(posedge clk_fpga or negedge rst_n) begin
    if (!rst_n) swing_d <= 1'b0;
    else        swing_d <= swing;
  end

  assign swing_rise = swing & ~swing_d;

  // One extra bit so the terminal compare cannot wrap at 31.
  assign idx_inc = {1'b0, idx_q} + (TICK_W+1)'(1);

  always_ff @(posedge clk_fpga or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PH_IDLE;
      res_q   <= RES_MISS;
      idx_q   <= '0;
      valid_q <= 1'b0;
      wopen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      wopen_q <= wopen_d;
    end
  end

  // A swing is checked before the tick in RUNUP/WINDOW so that a swing on the
  // closing tick classifies on the pre-increment index and beats MISS.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
    case (state_q)
      PH_IDLE: begin
        if (bowl_start) begin
          state_d = PH_RUNUP;
          idx_d   = '0;
        end
      end
      PH_RUNUP: begin
        if (swing_rise) begin
          state_d = PH_RESULT;
          res_d   = RES_EARLY;
          valid_d = 1'b1;
          idx_d   = '0;
        end else if (tick) begin
          if (idx_inc == (TICK_W+1)'(RUNUP_TICKS)) begin
            state_d = PH_WINDOW;
            idx_d   = '0;
          end else begin
            idx_d = idx_inc[TICK_W-1:0];
          end
        end
      end
      PH_WINDOW: begin
        if (swing_rise) begin
          state_d = PH_RESULT;
          valid_d = 1'b1;
          idx_d   = '0;
          if (idx_q < TICK_W'(PERFECT_LO))       res_d = RES_EARLY;
          else if (idx_q > TICK_W'(PERFECT_HI))  res_d = RES_LATE;
          else                                   res_d = RES_PERFECT;
        end else if (tick) begin
          if (idx_inc == (TICK_W+1)'(WINDOW_TICKS)) begin
            state_d = PH_RESULT;
            res_d   = RES_MISS;
            valid_d = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d = idx_inc[TICK_W-1:0];
          end
        end
      end
      PH_RESULT: begin
        if (tick) begin
          if (idx_inc == (TICK_W+1)'(RESULT_TICKS)) begin
            state_d = PH_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_inc[TICK_W-1:0];
          end
        end
      end
      default: state_d = PH_IDLE;
    endcase
    wopen_d = (state_d == PH_WINDOW);
  end

  assign phase        = state_q;
  assign window_open  = wopen_q;
  assign result_valid = valid_q;
  assign result       = res_q;
  assign tick_idx     = idx_q;

`ifdef SHOT_STATS_EN
  logic [7:0] balls_q, perf_q;

  always_ff @(posedge clk_fpga or negedge rst_n) begin
    if (!rst_n) begin
      balls_q <= '0;
      perf_q  <= '0;
    end else if (valid_d) begin
      balls_q <= sat_inc8(balls_q);
      if (res_d == RES_PERFECT) perf_q <= sat_inc8(perf_q);
    end
  end

  assign ball_count    = balls_q;
  assign perfect_count = perf_q;
`else
  assign ball_count    = '0;
  assign perfect_count = '0;
`endif

endmodule

// File: tb/tb_shot_window_timer.sv
module tb_shot_window_timer;

  logic       clk_fpga = 1'b0;
  logic       rst_n, clk_10Hz, bowl_start, swing;
  logic [1:0] phase, result;
  logic       window_open, result_valid;
  logic [4:0] tick_idx;
  logic [7:0] perfect_count, ball_count;

`ifdef SHOT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  shot_window_timer #(
    .RUNUP_TICKS  (20),
    .WINDOW_TICKS (8),
    .PERFECT_LO   (3),
    .PERFECT_HI   (4),
    .RESULT_TICKS (15)
  ) dut (
    .clk_fpga      (clk_fpga),
    .rst_n         (rst_n),
    .clk_10Hz      (clk_10Hz),
    .bowl_start    (bowl_start),
    .swing         (swing),
    .phase         (phase),
    .window_open   (window_open),
    .result_valid  (result_valid),
    .result        (result),
    .tick_idx      (tick_idx),
    .perfect_count (perfect_count),
    .ball_count    (ball_count)
  );

  always #5 clk_fpga = ~clk_fpga;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int exp_res;
  bit wo_seen = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every result_valid pulse consumes one expected result.
  always @(negedge clk_fpga) begin
    if (window_open) wo_seen = 1'b1;
    if (result_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result_valid", 1, 0);
      end else begin
        exp_res = exp_q.pop_front();
        chk("result", int'(result), exp_res);
        chk("phase_at_valid", int'(phase), 3);
      end
    end
  end

  // All stimulus is applied just after a falling edge; one cycle later the
  // registered outputs reflect it.
  task automatic tick(input int n);
    repeat (n) begin
      clk_10Hz = ~clk_10Hz;
      @(negedge clk_fpga);
    end
  endtask

  task automatic bowl();
    bowl_start = 1'b1;
    @(negedge clk_fpga);
    bowl_start = 1'b0;
  endtask

  task automatic swing_pulse();
    swing = 1'b1;
    @(negedge clk_fpga);
    swing = 1'b0;
    @(negedge clk_fpga);
  endtask

  task automatic swing_and_tick();
    swing    = 1'b1;
    clk_10Hz = ~clk_10Hz;
    @(negedge clk_fpga);
    swing = 1'b0;
    @(negedge clk_fpga);
  endtask

  task automatic run_window_swing(input int k, input int exp, input string tag);
    exp_q.push_back(exp);
    bowl();
    tick(20);
    chk({tag, "_window_open"}, int'(window_open), 1);
    tick(k);
    chk({tag, "_idx_before_swing"}, int'(tick_idx), k);
    swing_pulse();
    chk({tag, "_phase_result"}, int'(phase), 3);
    tick(15);
    chk({tag, "_phase_idle"}, int'(phase), 0);
  endtask

  task automatic run_miss(input string tag);
    exp_q.push_back(0);
    bowl();
    tick(28);
    chk({tag, "_phase_result"}, int'(phase), 3);
    tick(15);
    chk({tag, "_phase_idle"}, int'(phase), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clk_10Hz = 1'b0; bowl_start = 1'b0; swing = 1'b0;
    repeat (2) @(negedge clk_fpga);
    chk("rst_phase", int'(phase), 0);
    chk("rst_window_open", int'(window_open), 0);
    chk("rst_result_valid", int'(result_valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_tick_idx", int'(tick_idx), 0);
    chk("rst_ball_count", int'(ball_count), 0);
    chk("rst_perfect_count", int'(perfect_count), 0);
    rst_n = 1'b1;
    @(negedge clk_fpga);

    // Swing and ticks in IDLE do nothing.
    swing_pulse();
    tick(3);
    chk("idle_swing_ignored", int'(phase), 0);

    // Full delivery with no swing.
    exp_q.push_back(0);
    bowl();
    chk("miss_runup_phase", int'(phase), 1);
    chk("miss_runup_idx0", int'(tick_idx), 0);
    tick(19);
    chk("miss_runup_idx19", int'(tick_idx), 19);
    chk("miss_runup_still", int'(phase), 1);
    chk("miss_runup_wo", int'(window_open), 0);
    tick(1);
    chk("miss_window_phase", int'(phase), 2);
    chk("miss_window_wo", int'(window_open), 1);
    chk("miss_window_idx0", int'(tick_idx), 0);
    tick(7);
    chk("miss_window_idx7", int'(tick_idx), 7);
    chk("miss_window_still", int'(phase), 2);
    tick(1);
    chk("miss_result_phase", int'(phase), 3);
    chk("miss_result_valid", int'(result_valid), 1);
    chk("miss_result_wo", int'(window_open), 0);
    tick(1);
    chk("miss_valid_one_cycle", int'(result_valid), 0);
    tick(13);
    chk("miss_result_idx14", int'(tick_idx), 14);
    chk("miss_result_still", int'(phase), 3);
    tick(1);
    chk("miss_idle_phase", int'(phase), 0);
    chk("miss_idle_idx", int'(tick_idx), 0);

    // Window classification including both PERFECT boundaries.
    run_window_swing(3, 2, "w3_perfect");
    chk("w3_result_held", int'(result), 2);
    run_window_swing(0, 1, "w0_early");
    run_window_swing(2, 1, "w2_early");
    run_window_swing(4, 2, "w4_perfect");
    run_window_swing(5, 3, "w5_late");
    run_window_swing(6, 3, "w6_late");
    run_window_swing(7, 3, "w7_late");

    // Swing during RUNUP, then a second swing that must be ignored.
    wo_seen = 1'b0;
    exp_q.push_back(1);
    bowl();
    tick(10);
    chk("runup_idx10", int'(tick_idx), 10);
    swing_pulse();
    chk("runup_swing_phase", int'(phase), 3);
    chk("runup_swing_result", int'(result), 1);
    swing_pulse();
    chk("second_swing_phase", int'(phase), 3);
    chk("second_swing_result", int'(result), 1);
    tick(15);
    chk("runup_swing_idle", int'(phase), 0);
    chk("runup_swing_no_window", int'(wo_seen), 0);

    // Swing together with the final run-up tick: EARLY, window never opens.
    wo_seen = 1'b0;
    exp_q.push_back(1);
    bowl();
    tick(19);
    swing_and_tick();
    chk("runup_final_phase", int'(phase), 3);
    tick(15);
    chk("runup_final_idle", int'(phase), 0);
    chk("runup_final_no_window", int'(wo_seen), 0);

    // bowl_start during WINDOW is ignored.
    exp_q.push_back(0);
    bowl();
    tick(22);
    bowl();
    chk("bowl_in_window_phase", int'(phase), 2);
    chk("bowl_in_window_idx", int'(tick_idx), 2);
    tick(6);
    chk("bowl_in_window_result", int'(phase), 3);
    tick(15);
    chk("bowl_in_window_idle", int'(phase), 0);

    // Swing on the window-closing tick: LATE, not MISS.
    exp_q.push_back(3);
    bowl();
    tick(27);
    swing_and_tick();
    chk("close_swing_phase", int'(phase), 3);
    chk("close_swing_result", int'(result), 3);
    tick(15);
    chk("close_swing_idle", int'(phase), 0);

    chk("stats_before_reset", int'(ball_count), STATS ? 12 : 0);

    // Asynchronous reset in the middle of RUNUP.
    bowl();
    tick(5);
    chk("mid_reset_idx5", int'(tick_idx), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_phase", int'(phase), 0);
    chk("async_rst_idx", int'(tick_idx), 0);
    chk("async_rst_result", int'(result), 0);
    chk("async_rst_wo", int'(window_open), 0);
    chk("async_rst_valid", int'(result_valid), 0);
    chk("async_rst_balls", int'(ball_count), 0);
    chk("async_rst_perfect", int'(perfect_count), 0);
    @(negedge clk_fpga);
    rst_n = 1'b1;
    @(negedge clk_fpga);
    chk("after_reset_idle", int'(phase), 0);

    // Statistics: PERFECT, MISS, PERFECT.
    run_window_swing(3, 2, "stats_p1");
    run_miss("stats_miss");
    run_window_swing(4, 2, "stats_p2");
    chk("stats_ball_count", int'(ball_count), STATS ? 3 : 0);
    chk("stats_perfect_count", int'(perfect_count), STATS ? 2 : 0);

`ifdef SHOT_STATS_EN
    for (int i = 0; i < 300; i++) run_window_swing(3, 2, "sat");
    chk("sat_ball_count", int'(ball_count), 255);
    chk("sat_perfect_count", int'(perfect_count), 255);
`endif

    repeat (3) @(negedge clk_fpga);
    chk("pending_expected_results", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
